// File: rtl/matrix_job_feeder_if.sv
// Bundle of the operand stream, result stream and 2x2 multiplier handshake
// seen by matrix_job_feeder; master is the feeder, slave is its environment.
interface matrix_job_feeder_if;
    logic [31:0] in_Data;
    logic        in_Valid;
    logic        in_Ready;

    logic [31:0] out_Data;
    logic        out_Valid;
    logic        out_Ready;

    logic [31:0] mul_A11, mul_A12, mul_A21, mul_A22;
    logic [31:0] mul_B11, mul_B12, mul_B21, mul_B22;
    logic        mul_Stable;
    logic        mul_AB_Ack;

    logic [31:0] mul_C11, mul_C12, mul_C21, mul_C22;
    logic        mul_C_Stable;
    logic        mul_C_Ack;

    modport master (
        input  in_Data, in_Valid, out_Ready,
        input  mul_AB_Ack, mul_C11, mul_C12, mul_C21, mul_C22, mul_C_Stable,
        output in_Ready, out_Data, out_Valid,
        output mul_A11, mul_A12, mul_A21, mul_A22,
        output mul_B11, mul_B12, mul_B21, mul_B22,
        output mul_Stable, mul_C_Ack
    );

    modport slave (
        output in_Data, in_Valid, out_Ready,
        output mul_AB_Ack, mul_C11, mul_C12, mul_C21, mul_C22, mul_C_Stable,
        input  in_Ready, out_Data, out_Valid,
        input  mul_A11, mul_A12, mul_A21, mul_A22,
        input  mul_B11, mul_B12, mul_B21, mul_B22,
        input  mul_Stable, mul_C_Ack
    );
endinterface

// File: rtl/matrix_job_feeder.sv
// Collects eight operand words into a 2x2 multiplier job, runs the 4-phase
// operand/result handshakes with a timeout, then streams the four results out.
module matrix_job_feeder #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                input_Clk,
    input  logic                input_Reset,
    matrix_job_feeder_if.master bus,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_REQ,
        S_WAIT_RES,
        S_ACK,
        S_DRAIN,
        S_ERR
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [15:0] to_cnt;
    logic [31:0] op_q  [8];
    logic [31:0] res_q [4];

    logic in_fire;
    logic out_fire;
    logic timed;
    logic timeout;

    assign in_fire  = (state == S_LOAD) && bus.in_Valid;
    assign out_fire = (state == S_DRAIN) && bus.out_Ready;
    assign timed    = (state == S_REQ) || (state == S_WAIT_RES) || (state == S_ACK);
    assign timeout  = (to_cnt == TO_LAST);

    // Operands stay on the multiplier pins from job launch until the next LOAD.
    assign bus.mul_A11 = op_q[0];
    assign bus.mul_A12 = op_q[1];
    assign bus.mul_A21 = op_q[2];
    assign bus.mul_A22 = op_q[3];
    assign bus.mul_B11 = op_q[4];
    assign bus.mul_B12 = op_q[5];
    assign bus.mul_B21 = op_q[6];
    assign bus.mul_B22 = op_q[7];

    // NOTE: every output and state_next gets a default before the case, so no
    // path through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        bus.in_Ready  = 1'b0;
        bus.out_Valid = 1'b0;
        bus.out_Data  = '0;
        bus.mul_Stable = 1'b0;
        bus.mul_C_Ack = 1'b0;
        busy          = 1'b1;
        err           = 1'b0;

        case (state)
            S_LOAD: begin
                bus.in_Ready = 1'b1;
                busy         = (cnt != 3'd0);
                if (in_fire && cnt == 3'd7) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                bus.mul_Stable = 1'b1;
                if (bus.mul_AB_Ack) begin
                    state_next = S_WAIT_RES;
                end else if (timeout) begin
                    state_next = S_ERR;
                end
            end
            S_WAIT_RES: begin
                if (bus.mul_C_Stable) begin
                    state_next = S_ACK;
                end else if (timeout) begin
                    state_next = S_ERR;
                end
            end
            S_ACK: begin
                bus.mul_C_Ack = 1'b1;
                if (!bus.mul_C_Stable) begin
                    state_next = S_DRAIN;
                end else if (timeout) begin
                    state_next = S_ERR;
                end
            end
            S_DRAIN: begin
                bus.out_Valid = 1'b1;
                bus.out_Data  = res_q[cnt[1:0]];
                if (out_fire && cnt[1:0] == 2'd3) begin
                    state_next = S_LOAD;
                end
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order within the block.
    always_ff @(posedge input_Clk or negedge input_Reset) begin
        if (!input_Reset) begin
            state  <= S_LOAD;
            cnt    <= 3'd0;
            to_cnt <= 16'd0;
        end else begin
            state <= state_next;

            // The timeout budget restarts on every phase change.
            if (state_next != state) begin
                to_cnt <= 16'd0;
            end else if (timed) begin
                to_cnt <= to_cnt + 16'd1;
            end

            // One counter serves both the load index (wraps 7->0) and the drain index.
            if (in_fire) begin
                cnt <= cnt + 3'd1;
            end else if (out_fire) begin
                cnt <= (cnt[1:0] == 2'd3) ? 3'd0 : cnt + 3'd1;
            end
        end
    end

    // NOTE: these arrays are plain flops, not RAM, and are reset so that an
    // aborted job leaves nothing behind on the mul_* pins or out_Data.
    always_ff @(posedge input_Clk or negedge input_Reset) begin
        if (!input_Reset) begin
            for (int i = 0; i < 8; i++) begin
                op_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            if (in_fire) begin
                op_q[cnt] <= bus.in_Data;
            end
            if (state == S_WAIT_RES && bus.mul_C_Stable) begin
                res_q[0] <= bus.mul_C11;
                res_q[1] <= bus.mul_C12;
                res_q[2] <= bus.mul_C21;
                res_q[3] <= bus.mul_C22;
            end
        end
    end

endmodule

// File: tb/tb_matrix_job_feeder.sv
// Directed bench for matrix_job_feeder: a behavioural multiplier responder drives
// the handshake, and a monitor scores every transferred output word against a queue.
module tb_matrix_job_feeder;

    logic input_Clk = 1'b0;
    logic input_Reset;
    logic rst_to_n;
    logic busy, err;
    logic busy_to, err_to;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    matrix_job_feeder_if ifc ();
    matrix_job_feeder_if ifc_to ();

    matrix_job_feeder dut (
        .input_Clk   (input_Clk),
        .input_Reset (input_Reset),
        .bus         (ifc),
        .busy        (busy),
        .err         (err)
    );

    matrix_job_feeder #(.TIMEOUT_CYCLES(16)) dut_to (
        .input_Clk   (input_Clk),
        .input_Reset (rst_to_n),
        .bus         (ifc_to),
        .busy        (busy_to),
        .err         (err_to)
    );

    always #5 input_Clk = ~input_Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] op_word(input int i);
        case (i)
            0: return ifc.mul_A11;
            1: return ifc.mul_A12;
            2: return ifc.mul_A21;
            3: return ifc.mul_A22;
            4: return ifc.mul_B11;
            5: return ifc.mul_B12;
            6: return ifc.mul_B21;
            default: return ifc.mul_B22;
        endcase
    endfunction

    // Scoreboard monitor: one pop per accepted output word.
    always @(negedge input_Clk) begin
        if (input_Reset && ifc.out_Valid === 1'b1 && ifc.out_Ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected_valid", {31'd0, ifc.out_Valid}, 32'd0);
            end else begin
                check("out_word", ifc.out_Data, exp_q.pop_front());
            end
        end
    end

    task automatic send_words(input logic [0:7][31:0] w, input int n, input bit toggle);
        int i = 0;
        int p = 0;
        int n_cyc = 0;
        while (i < n && n_cyc < 100) begin
            @(negedge input_Clk);
            n_cyc++;
            if (toggle && p[0]) begin
                ifc.in_Valid = 1'b0;
            end else begin
                ifc.in_Valid = 1'b1;
                ifc.in_Data  = w[i];
                if (ifc.in_Ready) i++;
            end
            p++;
        end
        @(negedge input_Clk);
        ifc.in_Valid = 1'b0;
        ifc.in_Data  = 32'h0;
        n_cyc++;
        if (n == 8) begin
            check("first_req_stable", {31'd0, ifc.mul_Stable}, 32'd1);
            check("req_in_ready", {31'd0, ifc.in_Ready}, 32'd0);
            if (toggle) check("toggle_cycles", n_cyc, 16);
        end
    endtask

    task automatic respond(input logic [0:7][31:0] w, input int ab_delay, input int res_delay,
                           input int hold, input logic [0:3][31:0] c);
        int n = 0;
        while (ifc.mul_Stable !== 1'b1 && n < 200) begin
            @(negedge input_Clk);
            n++;
        end
        check("stable_rise", {31'd0, ifc.mul_Stable}, 32'd1);
        for (int i = 0; i < 8; i++) check($sformatf("operand_%0d", i), op_word(i), w[i]);
        repeat (ab_delay) @(negedge input_Clk);
        check("stable_held", {31'd0, ifc.mul_Stable}, 32'd1);
        ifc.mul_AB_Ack = 1'b1;
        @(negedge input_Clk);
        check("stable_fall", {31'd0, ifc.mul_Stable}, 32'd0);
        ifc.mul_AB_Ack = 1'b0;
        repeat (res_delay) @(negedge input_Clk);
        check("c_ack_idle", {31'd0, ifc.mul_C_Ack}, 32'd0);
        ifc.mul_C11 = c[0];
        ifc.mul_C12 = c[1];
        ifc.mul_C21 = c[2];
        ifc.mul_C22 = c[3];
        ifc.mul_C_Stable = 1'b1;
        @(negedge input_Clk);
        check("c_ack_rise", {31'd0, ifc.mul_C_Ack}, 32'd1);
        for (int h = 1; h < hold; h++) begin
            @(negedge input_Clk);
            check("c_ack_held", {31'd0, ifc.mul_C_Ack}, 32'd1);
        end
        ifc.mul_C_Stable = 1'b0;
        ifc.mul_C11 = 32'hDEADBEEF;
        ifc.mul_C12 = 32'hDEADBEEF;
        ifc.mul_C21 = 32'hDEADBEEF;
        ifc.mul_C22 = 32'hDEADBEEF;
        @(negedge input_Clk);
        check("c_ack_fall", {31'd0, ifc.mul_C_Ack}, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("operand_hold_%0d", i), op_word(i), w[i]);
    endtask

    // Returns at the first DRAIN cycle (negedge after mul_C_Ack falls).
    task automatic run_job(input logic [0:7][31:0] w, input bit toggle, input int ab_delay,
                           input int res_delay, input int hold, input logic [0:3][31:0] c);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[i]);
        fork
            send_words(w, 8, toggle);
            respond(w, ab_delay, res_delay, hold, c);
        join
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge input_Clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    logic [0:7][31:0] job_a;
    logic [0:3][31:0] res_a;

    initial begin
        ifc.in_Data = '0;    ifc.in_Valid = 1'b0;  ifc.out_Ready = 1'b1;
        ifc.mul_AB_Ack = 1'b0; ifc.mul_C_Stable = 1'b0;
        ifc.mul_C11 = '0; ifc.mul_C12 = '0; ifc.mul_C21 = '0; ifc.mul_C22 = '0;
        ifc_to.in_Data = '0; ifc_to.in_Valid = 1'b0; ifc_to.out_Ready = 1'b1;
        ifc_to.mul_AB_Ack = 1'b0; ifc_to.mul_C_Stable = 1'b0;
        ifc_to.mul_C11 = '0; ifc_to.mul_C12 = '0; ifc_to.mul_C21 = '0; ifc_to.mul_C22 = '0;
        input_Reset = 1'b0;
        rst_to_n    = 1'b0;

        // Reset state
        repeat (3) @(negedge input_Clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_out_valid", {31'd0, ifc.out_Valid}, 32'd0);
        check("rst_out_data", ifc.out_Data, 32'd0);
        check("rst_mul_stable", {31'd0, ifc.mul_Stable}, 32'd0);
        check("rst_c_ack", {31'd0, ifc.mul_C_Ack}, 32'd0);
        check("rst_mul_a11", ifc.mul_A11, 32'd0);
        input_Reset = 1'b1;
        rst_to_n    = 1'b1;
        @(negedge input_Clk);
        check("rst_in_ready", {31'd0, ifc.in_Ready}, 32'd1);

        // Timeout: TIMEOUT_CYCLES=16 and mul_AB_Ack never comes
        for (int i = 0; i < 8; i++) begin
            @(negedge input_Clk);
            ifc_to.in_Valid = 1'b1;
            ifc_to.in_Data  = 32'(i + 1);
        end
        @(negedge input_Clk);
        ifc_to.in_Valid = 1'b0;
        check("to_stable_first", {31'd0, ifc_to.mul_Stable}, 32'd1);
        repeat (15) @(negedge input_Clk);
        check("to_err_16th", {31'd0, err_to}, 32'd0);
        check("to_stable_16th", {31'd0, ifc_to.mul_Stable}, 32'd1);
        @(negedge input_Clk);
        check("to_err_set", {31'd0, err_to}, 32'd1);
        check("to_stable_off", {31'd0, ifc_to.mul_Stable}, 32'd0);
        check("to_in_ready", {31'd0, ifc_to.in_Ready}, 32'd0);
        ifc_to.mul_AB_Ack = 1'b1;
        repeat (3) @(negedge input_Clk);
        ifc_to.mul_AB_Ack = 1'b0;
        check("to_err_sticky", {31'd0, err_to}, 32'd1);
        check("to_busy", {31'd0, busy_to}, 32'd1);
        rst_to_n = 1'b0;
        #1;
        check("to_err_cleared", {31'd0, err_to}, 32'd0);
        @(negedge input_Clk);
        rst_to_n = 1'b1;

        // Job 1: A=I, B=[1 2;3 4], 20-cycle responder, no-bubble drain
        job_a = {32'h3F800000, 32'h0, 32'h0, 32'h3F800000,
                 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        res_a = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        run_job(job_a, 1'b0, 2, 20, 1, res_a);
        for (int k = 0; k < 4; k++) begin
            check("drain_no_bubble", {31'd0, ifc.out_Valid}, 32'd1);
            @(negedge input_Clk);
        end
        check("post_drain_valid", {31'd0, ifc.out_Valid}, 32'd0);
        check("post_drain_in_ready", {31'd0, ifc.in_Ready}, 32'd1);
        check("post_drain_busy", {31'd0, busy}, 32'd0);
        wait_drain();

        // Job 2: toggling in_Valid, A=2I, responder holds C_Stable 5 cycles
        job_a = {32'h40000000, 32'h0, 32'h0, 32'h40000000,
                 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        res_a = {32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
        run_job(job_a, 1'b1, 1, 4, 5, res_a);
        wait_drain();

        // Job 3: A=[1 2;3 4], B=I, sink stalls 10 cycles in DRAIN
        job_a = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h3F800000, 32'h0, 32'h0, 32'h3F800000};
        res_a = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        ifc.out_Ready = 1'b0;
        run_job(job_a, 1'b0, 0, 3, 1, res_a);
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", {31'd0, ifc.out_Valid}, 32'd1);
            check("stall_data", ifc.out_Data, 32'h3F800000);
            @(negedge input_Clk);
        end
        ifc.out_Ready = 1'b1;
        wait_drain();
        @(negedge input_Clk);
        check("stall_done_in_ready", {31'd0, ifc.in_Ready}, 32'd1);

        // Reset after the 5th word, then a fresh job
        job_a = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        send_words(job_a, 5, 1'b0);
        check("partial_busy", {31'd0, busy}, 32'd1);
        check("partial_a11", ifc.mul_A11, 32'h11111111);
        #2;
        input_Reset = 1'b0;
        #1;
        check("async_rst_a11", ifc.mul_A11, 32'd0);
        check("async_rst_b11", ifc.mul_B11, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_in_ready", {31'd0, ifc.in_Ready}, 32'd1);
        check("async_rst_out_valid", {31'd0, ifc.out_Valid}, 32'd0);
        check("async_rst_out_data", ifc.out_Data, 32'd0);
        @(negedge input_Clk);
        input_Reset = 1'b1;
        @(negedge input_Clk);
        check("post_rst_in_ready", {31'd0, ifc.in_Ready}, 32'd1);
        job_a = {32'h3F800000, 32'h0, 32'h0, 32'h3F800000,
                 32'h40000000, 32'h0, 32'h0, 32'h40000000};
        res_a = {32'h40000000, 32'h0, 32'h0, 32'h40000000};
        run_job(job_a, 1'b0, 0, 2, 1, res_a);
        wait_drain();

        // Stray multiplier handshakes while idle are ignored
        @(negedge input_Clk);
        ifc.mul_AB_Ack   = 1'b1;
        ifc.mul_C_Stable = 1'b1;
        repeat (2) @(negedge input_Clk);
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_in_ready", {31'd0, ifc.in_Ready}, 32'd1);
        check("stray_c_ack", {31'd0, ifc.mul_C_Ack}, 32'd0);
        ifc.mul_AB_Ack   = 1'b0;
        ifc.mul_C_Stable = 1'b0;
        repeat (2) @(negedge input_Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
